// File: rtl/alu_seq_if.sv
// Handshake/data bundle for the sequential ALU.
// Optional CARRY/OVERFLOW present when ALU_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [SEL_W-1:0] SELECT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;
`ifdef ALU_FLAGS_EN
  logic             CARRY;
  logic             OVERFLOW;
`endif

  modport master (
    output IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, ZERO
`ifdef ALU_FLAGS_EN
    , input CARRY, OVERFLOW
`endif
  );

  modport slave (
    input  IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, ZERO
`ifdef ALU_FLAGS_EN
    , output CARRY, OVERFLOW
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: 1-cycle logic/arith, iterative shifts and MUL.
// Define ALU_FLAGS_EN to add registered CARRY/OVERFLOW outputs.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter int SHIFT_STEP = 1,
  parameter int SEL_W      = 4
) (
  input logic       CLK,
  input logic       RESET,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    STEP = CW'(SHIFT_STEP);
  localparam logic [WIDTH-1:0] WV   = WIDTH'(WIDTH);

  localparam logic [SEL_W-1:0] OP_FWD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SLL = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SRL = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SRA = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_ROR = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(9);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] op_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] mc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             vld_q;

  // Up to SHIFT_STEP single-bit moves, k of them actually applied.
  function automatic logic [WIDTH-1:0] sh_val(
    input logic [SEL_W-1:0] op,
    input logic [WIDTH-1:0] v,
    input logic [CW-1:0]    k
  );
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (CW'(i) < k) begin
        case (op)
          OP_SLL:  r = {r[WIDTH-2:0], 1'b0};
          OP_SRL:  r = {1'b0, r[WIDTH-1:1]};
          OP_SRA:  r = {r[WIDTH-1], r[WIDTH-1:1]};
          default: r = {r[0], r[WIDTH-1:1]};
        endcase
      end
    end
    return r;
  endfunction

  // One shift-add multiply step on {hi, lo}; lo starts as multiplier.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] mc
  );
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    return {s, lo[WIDTH-1:1]};
  endfunction

`ifdef ALU_FLAGS_EN
  logic carry_q;
  logic ovf_q;
  logic a_c, a_v, e_c;
  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;

  // Last bit pushed out by a k-bit step (0 when k is 0).
  function automatic logic sh_cout(
    input logic [SEL_W-1:0] op,
    input logic [WIDTH-1:0] v,
    input logic [CW-1:0]    k
  );
    logic c;
    c = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (CW'(i + 1) == k) c = (op == OP_SLL) ? v[WIDTH-1-i] : v[i];
    end
    return c;
  endfunction

  assign add_w = {1'b0, bus.DATA1} + {1'b0, bus.DATA2};
  assign sub_w = {1'b0, bus.DATA1} + {1'b0, ~bus.DATA2} + (WIDTH+1)'(1);
`endif

  logic [WIDTH-1:0] a_val, a_hi, a_res;
  logic [CW-1:0]    a_cnt, a_amt, a_k;
  logic             a_fin;
  logic [WIDTH-1:0] e_val, e_hi;
  logic [CW-1:0]    e_cnt, e_k;
  logic             e_fin;

  // Work done on the accept edge, including the first iteration.
  always_comb begin
    a_val = '0;
    a_hi  = '0;
    a_cnt = '0;
    a_amt = '0;
    a_k   = '0;
    a_fin = 1'b1;
    a_res = '0;
`ifdef ALU_FLAGS_EN
    a_c = 1'b0;
    a_v = 1'b0;
`endif
    case (bus.SELECT)
      OP_FWD: a_res = bus.DATA2;
      OP_ADD: begin
        a_res = bus.DATA1 + bus.DATA2;
`ifdef ALU_FLAGS_EN
        a_c = add_w[WIDTH];
        a_v = (bus.DATA1[WIDTH-1] == bus.DATA2[WIDTH-1]) &&
              (add_w[WIDTH-1] != bus.DATA1[WIDTH-1]);
`endif
      end
      OP_AND: a_res = bus.DATA1 & bus.DATA2;
      OP_OR:  a_res = bus.DATA1 | bus.DATA2;
      OP_SUB: begin
        a_res = bus.DATA1 - bus.DATA2;
`ifdef ALU_FLAGS_EN
        a_c = sub_w[WIDTH];
        a_v = (bus.DATA1[WIDTH-1] != bus.DATA2[WIDTH-1]) &&
              (sub_w[WIDTH-1] != bus.DATA1[WIDTH-1]);
`endif
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
        if (bus.SELECT == OP_ROR)
          a_amt = CW'(bus.DATA2 % WV);
        else if (bus.DATA2 > WV)
          a_amt = CW'(WIDTH);
        else
          a_amt = CW'(bus.DATA2);
        a_k   = (a_amt < STEP) ? a_amt : STEP;
        a_val = sh_val(bus.SELECT, bus.DATA1, a_k);
        a_cnt = a_amt - a_k;
        a_fin = (a_cnt == '0);
        a_res = a_val;
`ifdef ALU_FLAGS_EN
        a_c = sh_cout(bus.SELECT, bus.DATA1, a_k);
`endif
      end
      OP_MUL: begin
        {a_hi, a_val} = mul_step('0, bus.DATA2, bus.DATA1);
        a_cnt = CW'(WIDTH - 1);
        a_fin = 1'b0;
      end
      default: a_res = '0;
    endcase
  end

  // One iteration of the op held in the working registers.
  always_comb begin
    e_k   = (cnt_q < STEP) ? cnt_q : STEP;
    e_hi  = hi_q;
    e_val = sh_val(op_q, val_q, e_k);
    e_cnt = cnt_q - e_k;
    e_fin = (e_cnt == '0);
`ifdef ALU_FLAGS_EN
    e_c = sh_cout(op_q, val_q, e_k);
`endif
    if (op_q == OP_MUL) begin
      {e_hi, e_val} = mul_step(hi_q, val_q, mc_q);
      e_cnt = cnt_q - CW'(1);
      e_fin = (cnt_q == CW'(1));
`ifdef ALU_FLAGS_EN
      e_c = |e_hi;
`endif
    end
  end

  // Control FSM with registered result, ZERO and OUT_VALID.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      val_q   <= '0;
      hi_q    <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (bus.IN_VALID) begin
          op_q  <= bus.SELECT;
          mc_q  <= bus.DATA1;
          val_q <= a_val;
          hi_q  <= a_hi;
          cnt_q <= a_cnt;
          if (a_fin) begin
            res_q   <= a_res;
            zero_q  <= (a_res == '0);
            vld_q   <= 1'b1;
            state_q <= S_DONE;
`ifdef ALU_FLAGS_EN
            carry_q <= a_c;
            ovf_q   <= a_v;
`endif
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          val_q <= e_val;
          hi_q  <= e_hi;
          cnt_q <= e_cnt;
          if (e_fin) begin
            res_q   <= e_val;
            zero_q  <= (e_val == '0);
            vld_q   <= 1'b1;
            state_q <= S_DONE;
`ifdef ALU_FLAGS_EN
            carry_q <= e_c;
            ovf_q   <= 1'b0;
`endif
          end
        end
        S_DONE: if (bus.OUT_READY) begin
          vld_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state_q == S_IDLE);
  assign bus.OUT_VALID = vld_q;
  assign bus.RESULT    = res_q;
  assign bus.ZERO      = zero_q;
`ifdef ALU_FLAGS_EN
  assign bus.CARRY     = carry_q;
  assign bus.OVERFLOW  = ovf_q;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model plus directed vectors.
// Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int STEP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(W), .SEL_W(4)) bus ();

  alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP), .SEL_W(4)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Reference: results from plain arithmetic on the operands.
  function automatic void model(input logic [3:0] sel,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] r,
                                output int lat,
                                output logic c,
                                output logic v);
    int amt, sa, sb, d;
    logic [2*W-1:0] p;
    logic signed [W-1:0] s8;
    r = '0; lat = 1; c = 1'b0; v = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    amt = 0;
    case (sel)
      4'd0: r = b;
      4'd1: begin
        p = a + b; r = p[W-1:0]; c = p[W];
        d = sa + sb; v = (d > 2**(W-1) - 1) || (d < -(2**(W-1)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: begin
        r = a - b; c = (a >= b);
        d = sa - sb; v = (d > 2**(W-1) - 1) || (d < -(2**(W-1)));
      end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        if (sel == 4'd8) amt = int'(b) % W;
        else amt = (int'(b) > W) ? W : int'(b);
        lat = (amt == 0) ? 1 : (amt + STEP - 1) / STEP;
        s8 = a;
        case (sel)
          4'd5: begin
            p = {{W{1'b0}}, a} << amt;
            r = p[W-1:0];
            c = (amt == 0) ? 1'b0 : p[W];
          end
          4'd6: r = a >> amt;
          4'd7: r = s8 >>> amt;
          default: r = (a >> amt) | (a << (W - amt));
        endcase
        if (sel != 4'd5) c = (amt == 0) ? 1'b0 : a[amt-1];
      end
      4'd9: begin
        p = a * b; r = p[W-1:0]; c = |p[2*W-1:W]; lat = W;
      end
      default: r = '0;
    endcase
  endfunction

  logic           pend = 1'b0;
  int             cyc = 0;
  int             acc_cyc = 0;
  logic [W-1:0]   m_r;
  int             m_lat;
  logic           m_c, m_v;

  // Every cycle: compare DUT against the model for the op in flight.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else begin
      chk("in_ready", {31'd0, bus.IN_READY}, {31'd0, !pend});
      if (pend) begin
        if (cyc - acc_cyc < m_lat) begin
          chk("early_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        end else begin
          chk("out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
          chk("result", {24'd0, bus.RESULT}, {24'd0, m_r});
          chk("zero", {31'd0, bus.ZERO}, {31'd0, m_r == '0});
`ifdef ALU_FLAGS_EN
          chk("carry", {31'd0, bus.CARRY}, {31'd0, m_c});
          chk("overflow", {31'd0, bus.OVERFLOW}, {31'd0, m_v});
`endif
          if (bus.OUT_READY) pend = 1'b0;
        end
      end else begin
        chk("idle_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        if (bus.IN_VALID) begin
          model(bus.SELECT, bus.DATA1, bus.DATA2, m_r, m_lat, m_c, m_v);
          pend = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  // Issue one op from posedge+1 with DUT idle; check hand-computed values.
  task automatic run(input string nm, input logic [3:0] sel,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input logic [W-1:0] r_lit,
                     input int lat_lit, input logic c_lit,
                     input logic v_lit);
    int t;
    bus.IN_VALID = 1'b1;
    bus.DATA1 = a;
    bus.DATA2 = b;
    bus.SELECT = sel;
    bus.OUT_READY = 1'b0;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    bus.DATA1 = ~a;
    bus.DATA2 = ~b;
    bus.SELECT = 4'd1;
    t = 1;
    while (!bus.OUT_VALID && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_lat"}, t, lat_lit);
    chk({nm, "_res"}, {24'd0, bus.RESULT}, {24'd0, r_lit});
`ifdef ALU_FLAGS_EN
    chk({nm, "_c"}, {31'd0, bus.CARRY}, {31'd0, c_lit});
    chk({nm, "_v"}, {31'd0, bus.OVERFLOW}, {31'd0, v_lit});
`else
    if (c_lit !== v_lit && c_lit === 1'bx) $display("unused");
`endif
    for (int i = 0; i < hold; i++) begin
      bus.IN_VALID = 1'b1;
      bus.DATA1 = 8'h11;
      bus.DATA2 = 8'h22;
      bus.SELECT = 4'd0;
      @(posedge clk); #1;
    end
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
  endtask

  initial begin
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;
    bus.SELECT = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", {24'd0, bus.RESULT}, 32'd0);
    chk("rst_zero", {31'd0, bus.ZERO}, 32'd0);
    chk("rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst_ready", {31'd0, bus.IN_READY}, 32'd1);
    rst = 1'b0;

    run("add7f", 4'd1, 8'h7F, 8'h01, 0, 8'h80, 1, 1'b0, 1'b1);
    run("sub55", 4'd4, 8'h05, 8'h05, 0, 8'h00, 1, 1'b1, 1'b0);
    run("sub01", 4'd4, 8'h00, 8'h01, 0, 8'hFF, 1, 1'b0, 1'b0);
    run("sra3",  4'd7, 8'h90, 8'd3,  0, 8'hF2, 3, 1'b0, 1'b0);
    run("sra9",  4'd7, 8'h90, 8'd9,  0, 8'hFF, 8, 1'b1, 1'b0);
    run("ror9",  4'd8, 8'h01, 8'd9,  0, 8'h80, 1, 1'b1, 1'b0);
    run("sll0",  4'd5, 8'h5A, 8'd0,  0, 8'h5A, 1, 1'b0, 1'b0);
    run("sll2",  4'd5, 8'h81, 8'd2,  0, 8'h04, 2, 1'b0, 1'b0);
    run("sllbig",4'd5, 8'h01, 8'd200,0, 8'h00, 8, 1'b1, 1'b0);
    run("srl4",  4'd6, 8'hF0, 8'd4,  0, 8'h0F, 4, 1'b0, 1'b0);
    run("mul1",  4'd9, 8'h0F, 8'h11, 0, 8'hFF, 8, 1'b0, 1'b0);
    run("mul2",  4'd9, 8'd13, 8'd20, 0, 8'h04, 8, 1'b1, 1'b0);
    run("fwd",   4'd0, 8'h00, 8'hA5, 0, 8'hA5, 1, 1'b0, 1'b0);
    run("and",   4'd2, 8'hCC, 8'hAA, 0, 8'h88, 1, 1'b0, 1'b0);
    run("or",    4'd3, 8'hCC, 8'hAA, 0, 8'hEE, 1, 1'b0, 1'b0);
    run("undef", 4'hF, 8'h12, 8'h34, 0, 8'h00, 1, 1'b0, 1'b0);
    run("hold",  4'd1, 8'h10, 8'h20, 5, 8'h30, 1, 1'b0, 1'b0);
    run("next",  4'd3, 8'h30, 8'h03, 0, 8'h33, 1, 1'b0, 1'b0);

    bus.IN_VALID = 1'b1;
    bus.DATA1 = 8'd13;
    bus.DATA2 = 8'd20;
    bus.SELECT = 4'd9;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", {24'd0, bus.RESULT}, 32'd0);
    chk("arst_zero", {31'd0, bus.ZERO}, 32'd0);
    chk("arst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("arst_ready", {31'd0, bus.IN_READY}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run("add23", 4'd1, 8'h02, 8'h03, 0, 8'h05, 1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
